xbar_bcast_arbiter: RTL and testbench

Sequences the shared coherence crossbar. One broadcast is in flight at a time. The block round-robin arbitrates among the NUM_CPUS cache controllers and the memory controller (NUM_NODES = NUM_CPUS+1 requesters). It grants the winner one broadcast cycle on its crossbar input, then collects snoop acks from the NUM_CPUS other nodes before releasing the crossbar. Sits beside the crossbar; the per-node controllers drive crossbar inputs only when granted.

---
 rtl/xbar_bcast_arbiter_pkg.sv | 17 +
 rtl/xbar_bcast_arbiter_rr_arbiter.sv | 37 +++
 rtl/xbar_bcast_arbiter.sv | 138 +++++++++++++
 tb/tb_xbar_bcast_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/xbar_bcast_arbiter_pkg.sv
// Shared types for the coherence crossbar broadcast sequencer.
package xbar_bcast_arbiter_pkg;

  localparam int NUM_CPUS   = 4;
  localparam int NUM_NODES  = NUM_CPUS + 1;
  localparam int NODE_IDX_W = $clog2(NUM_NODES);

  typedef logic [NUM_NODES-1:0] node_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    BCAST,
    WAIT_ACK,
    DONE
  } arb_state_t;

endpackage

// File: rtl/xbar_bcast_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  // One extra bit so ptr + offset can be wrapped without overflow.
  localparam int SW = IW + 1;

  logic [SW-1:0] pos;
  logic          found;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = '0;
    any_req = |req;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found               = 1'b1;
        gnt[pos[IW-1:0]]    = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/xbar_bcast_arbiter.sv
// Broadcast sequencer for the shared coherence crossbar: one broadcast in
// flight, round-robin grant, then wait for snoop acks from every other node.
module xbar_bcast_arbiter #(
  parameter int NUM_CPUS       = xbar_bcast_arbiter_pkg::NUM_CPUS,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int NN            = NUM_CPUS + 1,
  localparam int IW            = $clog2(NN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NN-1:0] req_i,
  output logic [NN-1:0] gnt_o,
  output logic          bcast_valid_o,
  output logic [IW-1:0] bcast_src_o,
  input  logic [NN-1:0] ack_i,
  output logic [NN-1:0] done_o,
  output logic          timeout_o,
  output logic          err_sticky_o,
  output logic          busy_o
);

  import xbar_bcast_arbiter_pkg::*;

  typedef logic [NN-1:0] mask_t;

  localparam int              TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]   LAST_NODE = IW'(NN - 1);

  arb_state_t    state, state_d;
  logic [IW-1:0] src, src_d;
  logic [IW-1:0] rr_ptr, rr_ptr_d;
  mask_t         ack_seen, ack_seen_d;
  mask_t         others;
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          tmo_flag, tmo_flag_d;

  mask_t         win_oh;
  logic [IW-1:0] win_idx;
  logic          win_any;

  // Output values for the next cycle; registered alongside the state.
  mask_t         gnt_d, done_d;
  logic          bv_d, timeout_d, busy_d;

  rr_arbiter #(.N(NN), .IW(IW)) u_rr (
    .req     (req_i),
    .ptr     (rr_ptr),
    .gnt     (win_oh),
    .idx     (win_idx),
    .any_req (win_any)
  );

  // Every node except the current source must ack.
  assign others = ~(mask_t'(1) << src);

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state;
    src_d      = src;
    rr_ptr_d   = rr_ptr;
    ack_seen_d = ack_seen;
    tmo_cnt_d  = tmo_cnt;
    tmo_flag_d = tmo_flag;
    gnt_d      = '0;
    bv_d       = 1'b0;
    case (state)
      IDLE: begin
        if (win_any) begin
          src_d    = win_idx;
          rr_ptr_d = (win_idx == LAST_NODE) ? '0 : win_idx + IW'(1);
          gnt_d    = win_oh;
          bv_d     = 1'b1;
          state_d  = BCAST;
        end
      end
      BCAST: begin
        // Acks during the broadcast cycle itself are not counted.
        ack_seen_d = '0;
        tmo_cnt_d  = '0;
        tmo_flag_d = 1'b0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        ack_seen_d = ack_seen | (ack_i & others);
        if (ack_seen_d == others) begin
          state_d = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d    = (state_d == DONE) ? (mask_t'(1) << src_d) : '0;
    timeout_d = (state_d == DONE) && tmo_flag_d;
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      src           <= '0;
      rr_ptr        <= '0;
      ack_seen      <= '0;
      tmo_cnt       <= '0;
      tmo_flag      <= 1'b0;
      gnt_o         <= '0;
      bcast_valid_o <= 1'b0;
      done_o        <= '0;
      timeout_o     <= 1'b0;
      err_sticky_o  <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_d;
      src           <= src_d;
      rr_ptr        <= rr_ptr_d;
      ack_seen      <= ack_seen_d;
      tmo_cnt       <= tmo_cnt_d;
      tmo_flag      <= tmo_flag_d;
      gnt_o         <= gnt_d;
      bcast_valid_o <= bv_d;
      done_o        <= done_d;
      timeout_o     <= timeout_d;
      err_sticky_o  <= err_sticky_o | timeout_d;
      busy_o        <= busy_d;
    end
  end

  assign bcast_src_o = src;

endmodule

// File: tb/tb_xbar_bcast_arbiter.sv
// Directed bench for xbar_bcast_arbiter with NUM_CPUS=4 (five nodes).
module tb_xbar_bcast_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_i, ack_i;
  logic [4:0] gnt_o, done_o;
  logic       bcast_valid_o, timeout_o, err_sticky_o, busy_o;
  logic [2:0] bcast_src_o;

  int checks   = 0;
  int failures = 0;

  xbar_bcast_arbiter #(.NUM_CPUS(4), .TIMEOUT_CYCLES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .bcast_valid_o (bcast_valid_o),
    .bcast_src_o   (bcast_src_o),
    .ack_i         (ack_i),
    .done_o        (done_o),
    .timeout_o     (timeout_o),
    .err_sticky_o  (err_sticky_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] req;
    logic [4:0] ack;
    logic [4:0] gnt;
    logic       bv;
    logic [2:0] src;
    logic [4:0] done;
    logic       tmo;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] r, logic [4:0] a, logic [4:0] g,
                              logic v, logic [2:0] s, logic [4:0] d, logic t, logic e, logic b);
    vec_t x;
    x.name = nm; x.req = r; x.ack = a; x.gnt = g; x.bv = v; x.src = s;
    x.done = d; x.tmo = t; x.err = e; x.busy = b;
    return x;
  endfunction

  // Source index is only meaningful while busy unless csrc forces the check.
  task automatic check(string nm, logic [4:0] eg, logic ev, logic [2:0] es, logic csrc,
                       logic [4:0] ed, logic et, logic ee, logic eb);
    logic ok;
    ok = (gnt_o === eg) && (bcast_valid_o === ev) && (done_o === ed) &&
         (timeout_o === et) && (err_sticky_o === ee) && (busy_o === eb) &&
         (!csrc || bcast_src_o === es);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got gnt=%b v=%b src=%0d done=%b tmo=%b err=%b busy=%b; want gnt=%b v=%b src=%0d done=%b tmo=%b err=%b busy=%b",
               nm, gnt_o, bcast_valid_o, bcast_src_o, done_o, timeout_o, err_sticky_o, busy_o,
               eg, ev, es, ed, et, ee, eb);
    end
  endtask

  // Drive inputs for one cycle, then sample just after the edge.
  task automatic step(input logic [4:0] r, input logic [4:0] a);
    req_i = r;
    ack_i = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    req_i = '0;
    ack_i = '0;

    // All five requesting: grants rotate 0,1,2,3,4,0, one every 4 cycles.
    for (int g = 0; g < 6; g++) begin
      logic [4:0] oh;
      logic [2:0] n;
      n  = 3'(g % 5);
      oh = 5'b00001 << n;
      vecs.push_back(mk("rr_bcast", 5'b11111, 5'b00000, oh,  1'b1, n, 5'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk("rr_wait",  5'b11111, 5'b00000, 5'b0, 1'b0, n, 5'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk("rr_done",  5'b11111, 5'b11111, 5'b0, 1'b0, n, oh,   1'b0, 1'b0, 1'b1));
      vecs.push_back(mk("rr_idle",  5'b11111, 5'b00000, 5'b0, 1'b0, n, 5'b0, 1'b0, 1'b0, 1'b0));
    end
    // Node 1 alone, acks from everyone else in the first wait cycle.
    vecs.push_back(mk("t1_bcast", 5'b00010, 5'b00000, 5'b00010, 1'b1, 3'd1, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t1_wait",  5'b00010, 5'b00000, 5'b00000, 1'b0, 3'd1, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t1_done",  5'b00010, 5'b11101, 5'b00000, 1'b0, 3'd1, 5'b00010, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t1_idle",  5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd1, 5'b0,     1'b0, 1'b0, 1'b0));
    // Memory controller alone; its own ack bit is never needed; ack in DONE dropped.
    vecs.push_back(mk("t6_bcast", 5'b10000, 5'b00000, 5'b10000, 1'b1, 3'd4, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t6_wait",  5'b10000, 5'b00000, 5'b00000, 1'b0, 3'd4, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t6_wait2", 5'b10000, 5'b00000, 5'b00000, 1'b0, 3'd4, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t6_done",  5'b10000, 5'b01111, 5'b00000, 1'b0, 3'd4, 5'b10000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t6_idle",  5'b00000, 5'b11111, 5'b00000, 1'b0, 3'd4, 5'b0,     1'b0, 1'b0, 1'b0));
    // Node 3: acks during BCAST ignored, duplicate and self acks ignored.
    vecs.push_back(mk("t4_bcast", 5'b01000, 5'b00000, 5'b01000, 1'b1, 3'd3, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_bcack", 5'b01000, 5'b10111, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_ack0",  5'b01000, 5'b00001, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_dup0",  5'b01000, 5'b00001, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_self",  5'b01000, 5'b01000, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_done",  5'b01000, 5'b10110, 5'b00000, 1'b0, 3'd3, 5'b01000, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk("t4_idle",  5'b00000, 5'b00000, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("t4_idlack",5'b00000, 5'b11111, 5'b00000, 1'b0, 3'd3, 5'b0,     1'b0, 1'b0, 1'b0));

    // Reset state.
    #12;
    check("reset", 5'b0, 1'b0, 3'd0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 5'b0, 1'b0, 3'd0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].ack);
      check(vecs[i].name, vecs[i].gnt, vecs[i].bv, vecs[i].src, vecs[i].busy,
            vecs[i].done, vecs[i].tmo, vecs[i].err, vecs[i].busy);
    end

    // Timeout: node 2 granted, node 4 never acks; 64 wait cycles then forced DONE.
    step(5'b00100, 5'b00000);
    check("t3_bcast", 5'b00100, 1'b1, 3'd2, 1'b1, 5'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      step(5'b00100, (i == 2) ? 5'b01011 : 5'b00000);
      check("t3_wait", 5'b0, 1'b0, 3'd2, 1'b1, 5'b0, 1'b0, 1'b0, 1'b1);
    end
    step(5'b00100, 5'b00000);
    check("t3_done_tmo", 5'b0, 1'b0, 3'd2, 1'b1, 5'b00100, 1'b1, 1'b1, 1'b1);
    step(5'b00000, 5'b00000);
    check("t3_idle_sticky", 5'b0, 1'b0, 3'd2, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);
    step(5'b00000, 5'b00000);
    check("t3_sticky_hold", 5'b0, 1'b0, 3'd2, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0);

    // Reset in WAIT_ACK: outputs clear immediately, no done afterwards.
    step(5'b00010, 5'b00000);
    check("t5_bcast", 5'b00010, 1'b1, 3'd1, 1'b1, 5'b0, 1'b0, 1'b1, 1'b1);
    step(5'b00010, 5'b00000);
    check("t5_wait", 5'b0, 1'b0, 3'd1, 1'b1, 5'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_rst", 5'b0, 1'b0, 3'd0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    req_i = 5'b00000;
    ack_i = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("t5_in_rst", 5'b0, 1'b0, 3'd0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(5'b00100, 5'b00000);
    check("t5_regrant", 5'b00100, 1'b1, 3'd2, 1'b1, 5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b00100, 5'b00000);
    check("t5_wait2", 5'b0, 1'b0, 3'd2, 1'b1, 5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b00100, 5'b11011);
    check("t5_done", 5'b0, 1'b0, 3'd2, 1'b1, 5'b00100, 1'b0, 1'b0, 1'b1);
    step(5'b00000, 5'b00000);
    check("t5_idle", 5'b0, 1'b0, 3'd2, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
